// File: rtl/sys_defs.sv
// Shared front-end definitions: the fetch packet layout and instruction-buffer defaults.
package sys_defs;

    localparam int FETCH_WIDTH   = 4;
    localparam int IB_DEPTH_DEF  = 16;
    localparam int DEQ_WIDTH_DEF = 3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        bp_pred_taken;
    } FETCH_PACKET;

endpackage

// File: rtl/ib_lane_compactor.sv
// Combinational lane filter: keeps valid lanes up to and including the first
// predicted-taken branch, and maps kept lanes onto contiguous write slots.
module ib_lane_compactor
    import sys_defs::*;
(
    input  logic                            i_bundle_valid,
    input  logic [FETCH_WIDTH-1:0]          i_valid,
    input  logic [FETCH_WIDTH-1:0]          i_is_branch,
    input  logic [FETCH_WIDTH-1:0]          i_pred_taken,
    output logic [FETCH_WIDTH-1:0]          o_keep,
    output logic [2:0]                      o_n_enq,
    output logic [FETCH_WIDTH-1:0][1:0]     o_slot_lane
);

    always_comb begin
        logic cut;
        cut = 1'b0;
        o_keep = '0;
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            o_keep[l] = i_bundle_valid && i_valid[l] && !cut;
            // Lanes younger than a predicted-taken branch are on the wrong path.
            if (i_is_branch[l] && i_pred_taken[l]) cut = 1'b1;
        end
    end

    always_comb begin
        int cnt;
        cnt = 0;
        o_slot_lane = '0;
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (o_keep[l]) begin
                o_slot_lane[cnt[1:0]] = 2'(l);
                cnt = cnt + 1;
            end
        end
        o_n_enq = 3'(cnt);
    end

endmodule

// File: rtl/instruction_buffer.sv
// Fetch-to-dispatch decoupling FIFO: absorbs compacted 4-wide fetch bundles and
// presents the oldest DEQ_WIDTH entries in program order.
module instruction_buffer
    import sys_defs::*;
#(
    parameter  int IB_DEPTH  = IB_DEPTH_DEF,
    parameter  int DEQ_WIDTH = DEQ_WIDTH_DEF,
    localparam int PTR_W     = $clog2(IB_DEPTH),
    localparam int CNT_W     = $clog2(IB_DEPTH + 1),
    localparam int DQ_W      = $clog2(DEQ_WIDTH + 1)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            ib_bundle_valid,
    input  FETCH_PACKET [FETCH_WIDTH-1:0]   fetch_packet,
    output logic                            ib_full,
    input  logic                            flush,
    input  logic [DQ_W-1:0]                 deq_count,
    output FETCH_PACKET [DEQ_WIDTH-1:0]     out_packet,
    output logic [DEQ_WIDTH-1:0]            out_valid,
    output logic [CNT_W-1:0]                ib_count
);

    FETCH_PACKET            r_mem [IB_DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic [FETCH_WIDTH-1:0]         w_valid;
    logic [FETCH_WIDTH-1:0]         w_is_branch;
    logic [FETCH_WIDTH-1:0]         w_pred_taken;
    logic [FETCH_WIDTH-1:0]         w_keep;
    logic [2:0]                     w_n_enq;
    logic [FETCH_WIDTH-1:0][1:0]    w_slot_lane;
    logic                           w_do_enq;
    logic [CNT_W-1:0]               w_n_enq_eff;
    logic [CNT_W-1:0]               w_deq_req;
    logic [CNT_W-1:0]               w_n_deq;
    logic [PTR_W-1:0]               w_wr_idx [FETCH_WIDTH];
    logic [PTR_W-1:0]               w_rd_idx [DEQ_WIDTH];

    always_comb begin
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            w_valid[l]      = fetch_packet[l].valid;
            w_is_branch[l]  = fetch_packet[l].is_branch;
            w_pred_taken[l] = fetch_packet[l].bp_pred_taken;
        end
    end

    ib_lane_compactor u_compactor (
        .i_bundle_valid (ib_bundle_valid),
        .i_valid        (w_valid),
        .i_is_branch    (w_is_branch),
        .i_pred_taken   (w_pred_taken),
        .o_keep         (w_keep),
        .o_n_enq        (w_n_enq),
        .o_slot_lane    (w_slot_lane)
    );

    // Full is judged on registered occupancy only, so a same-cycle dequeue never unblocks fetch.
    assign ib_full     = r_count > CNT_W'(IB_DEPTH - 4);
    assign w_do_enq    = ib_bundle_valid && !ib_full && !flush && (|w_keep);
    assign w_n_enq_eff = w_do_enq ? CNT_W'(w_n_enq) : '0;
    assign w_deq_req   = CNT_W'(deq_count);
    assign w_n_deq     = (w_deq_req > r_count) ? r_count : w_deq_req;

    always_comb begin
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            w_wr_idx[s] = r_tail + PTR_W'(s);
        end
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            w_rd_idx[i] = r_head + PTR_W'(i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_n_deq);
            r_tail  <= r_tail + PTR_W'(w_n_enq_eff);
            r_count <= r_count + w_n_enq_eff - w_n_deq;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            if (w_do_enq && (3'(s) < w_n_enq)) begin
                r_mem[w_wr_idx[s]] <= fetch_packet[w_slot_lane[s]];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            out_packet[i] = r_mem[w_rd_idx[i]];
            out_valid[i]  = CNT_W'(i) < r_count;
        end
    end

    assign ib_count = r_count;

endmodule

// File: tb/tb_instruction_buffer.sv
// Randomized plus directed bench for instruction_buffer with a queue-based reference model.
module tb_instruction_buffer;
    import sys_defs::*;

    localparam int DEPTH = 16;
    localparam int DW    = 3;
    localparam int CNT_W = 5;
    localparam int DQ_W  = 2;

    logic                   clock;
    logic                   reset_n;
    logic                   ib_bundle_valid;
    FETCH_PACKET [3:0]      fetch_packet;
    logic                   ib_full;
    logic                   flush;
    logic [DQ_W-1:0]        deq_count;
    FETCH_PACKET [DW-1:0]   out_packet;
    logic [DW-1:0]          out_valid;
    logic [CNT_W-1:0]       ib_count;

    typedef struct packed {
        logic [CNT_W-1:0]       count;
        logic                   full;
        logic [DW-1:0]          ov;
        FETCH_PACKET [DW-1:0]   pkt;
    } snap_t;

    snap_t       exp_q[$];
    FETCH_PACKET model_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] pc_next;

    instruction_buffer #(.IB_DEPTH(DEPTH), .DEQ_WIDTH(DW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ib_bundle_valid (ib_bundle_valid),
        .fetch_packet    (fetch_packet),
        .ib_full         (ib_full),
        .flush           (flush),
        .deq_count       (deq_count),
        .out_packet      (out_packet),
        .out_valid       (out_valid),
        .ib_count        (ib_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: compares each post-edge DUT view against the oldest expected snapshot.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                snap_t e;
                e = exp_q.pop_front();
                check("ib_count", 128'(ib_count), 128'(e.count));
                check("ib_full", 128'(ib_full), 128'(e.full));
                check("out_valid", 128'(out_valid), 128'(e.ov));
                for (int i = 0; i < DW; i++) begin
                    if (e.ov[i]) check($sformatf("out_packet[%0d]", i), 128'(out_packet[i]), 128'(e.pkt[i]));
                end
            end
        end
    end

    // Drive one cycle of stimulus and push the model's post-edge view.
    task automatic step(input logic bv, input FETCH_PACKET [3:0] lanes, input int deq, input logic fl);
        snap_t e;
        int    nd;
        bit    cut;
        bit    accept;
        @(negedge clock);
        ib_bundle_valid = bv;
        fetch_packet    = lanes;
        deq_count       = DQ_W'(deq);
        flush           = fl;
        if (fl) begin
            model_q.delete();
        end else begin
            accept = (model_q.size() <= DEPTH - 4);
            nd = (deq < model_q.size()) ? deq : model_q.size();
            repeat (nd) void'(model_q.pop_front());
            if (bv && accept) begin
                cut = 1'b0;
                for (int l = 0; l < 4; l++) begin
                    if (lanes[l].valid && !cut) model_q.push_back(lanes[l]);
                    if (lanes[l].is_branch && lanes[l].bp_pred_taken) cut = 1'b1;
                end
            end
        end
        e = '0;
        e.count = CNT_W'(model_q.size());
        e.full  = model_q.size() > DEPTH - 4;
        for (int i = 0; i < DW; i++) begin
            if (i < model_q.size()) begin
                e.ov[i]  = 1'b1;
                e.pkt[i] = model_q[i];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic make_bundle(output FETCH_PACKET [3:0] b, input logic [3:0] vmask, input int taken_lane);
        for (int l = 0; l < 4; l++) begin
            b[l].valid         = vmask[l];
            b[l].pc            = pc_next;
            b[l].inst          = $urandom;
            b[l].is_branch     = (l == taken_lane);
            b[l].bp_pred_taken = (l == taken_lane);
            pc_next            = pc_next + 32'd4;
        end
    endtask

    task automatic idle(input int deq);
        step(1'b0, '0, deq, 1'b0);
    endtask

    task automatic enq(input logic [3:0] vmask, input int taken_lane, input int deq);
        FETCH_PACKET [3:0] b;
        make_bundle(b, vmask, taken_lane);
        step(1'b1, b, deq, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        ib_bundle_valid = 1'b0;
        fetch_packet = '0;
        deq_count = '0;
        flush = 1'b0;
        model_q.delete();
        repeat (2) @(posedge clock);
        #1;
        check("reset ib_count", 128'(ib_count), 128'(0));
        check("reset ib_full", 128'(ib_full), 128'(0));
        check("reset out_valid", 128'(out_valid), 128'(0));
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        FETCH_PACKET [3:0] b;
        reset_n = 1'b0;
        ib_bundle_valid = 1'b0;
        fetch_packet = '0;
        deq_count = '0;
        flush = 1'b0;
        pc_next = 32'h1000;
        apply_reset();

        // Fill to full, then a fifth bundle that must be ignored.
        repeat (5) enq(4'b1111, -1, 0);
        repeat (6) idle(3);

        // Predicted-taken branch in lane 1 truncates the bundle.
        pc_next = 32'h100;
        enq(4'b1111, 1, 0);
        idle(0);
        repeat (2) idle(3);

        // Sparse valid lanes compact without holes.
        enq(4'b1010, -1, 0);
        idle(0);
        idle(3);

        // Over-request clamps while a full bundle enters in the same cycle.
        enq(4'b0011, -1, 0);
        enq(4'b1111, -1, 3);
        repeat (2) idle(3);

        // Move head to 14 and then enqueue across the wrap.
        apply_reset();
        repeat (3) enq(4'b1111, -1, 0);
        enq(4'b0011, -1, 0);
        repeat (4) idle(3);
        idle(2);
        enq(4'b1111, -1, 0);
        idle(0);
        idle(3);
        idle(0);
        idle(3);

        // Flush beats a simultaneous enqueue and dequeue at count 9.
        repeat (2) enq(4'b1111, -1, 0);
        enq(4'b0001, -1, 0);
        make_bundle(b, 4'b1111, -1);
        step(1'b1, b, 2, 1'b1);
        idle(0);

        // Asynchronous reset clears the outputs without an edge.
        repeat (2) enq(4'b1111, -1, 0);
        @(negedge clock);
        ib_bundle_valid = 1'b0;
        deq_count = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async ib_count", 128'(ib_count), 128'(0));
        check("async ib_full", 128'(ib_full), 128'(0));
        check("async out_valid", 128'(out_valid), 128'(0));
        model_q.delete();
        @(negedge clock);
        reset_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < 4; l++) begin
                b[l].valid         = $urandom_range(0, 3) != 0;
                b[l].pc            = pc_next;
                b[l].inst          = $urandom;
                b[l].is_branch     = b[l].valid && ($urandom_range(0, 3) == 0);
                b[l].bp_pred_taken = b[l].is_branch && ($urandom_range(0, 1) == 1);
                pc_next            = pc_next + 32'd4;
            end
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 3), $urandom_range(0, 31) == 0);
        end

        repeat (3) idle(0);
        @(posedge clock);
        #2;
        check("scoreboard drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
